pc_sequencer: RTL

Next-PC controller for the single-cycle MIPS core. Sits between the decoder/ALU outputs and the program counter register: computes the next PC (sequential, branch, jump, jump-register), and drives the register's `pc_in`/`pcWEN` pair so the PC advances only when instruction and data memory are ready. Holds a one-entry redirect buffer so a control transfer resolved during a stall is not lost, and latches the halt condition.

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/next_pc_calc.sv | 47 ++++
 rtl/pc_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, PC source select and pc_sequencer states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    SEQ = 2'd0,
    BR  = 2'd1,
    J   = 2'd2,
    JR  = 2'd3
  } pc_src_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    REDIR = 2'd1,
    HALT  = 2'd2,
    TRAP  = 2'd3
  } pcseq_state_t;

  localparam word_t PC_INIT_DEFAULT    = 32'h0000_0000;
  localparam word_t EXC_VECTOR_DEFAULT = 32'h0000_0080;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC target: sequential, branch, jump and jump-register.
module next_pc_calc
  import cpu_types_pkg::*;
(
  input  word_t       pc_out,
  input  pc_src_t     pc_src,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] jaddr,
  input  word_t       rs_data,
  output word_t       pc_plus4,
  output word_t       target,
  output logic        is_xfer
);

  word_t br_off;

  assign pc_plus4 = pc_out + 32'd4;
  assign br_off   = {{14{imm16[15]}}, imm16, 2'b00};

  // Select the target; is_xfer flags a real (non-sequential) control transfer
  always_comb begin
    target  = pc_plus4;
    is_xfer = 1'b0;
    case (pc_src)
      BR: begin
        if (br_taken) begin
          target  = pc_plus4 + br_off;
          is_xfer = 1'b1;
        end
      end
      J: begin
        target  = {pc_plus4[31:28], jaddr, 2'b00};
        is_xfer = 1'b1;
      end
      JR: begin
        target  = rs_data;
        is_xfer = 1'b1;
      end
      default: begin
        target  = pc_plus4;
        is_xfer = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: drives pc_in/pcWEN, buffers a control transfer resolved
// during a data stall, and latches HALT.
// Optional feature macro: PC_ALIGN_TRAP_EN (misaligned target traps to
// EXC_VECTOR through a one-cycle TRAP state, adds the misalign output).
module pc_sequencer
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT    = PC_INIT_DEFAULT,
  parameter word_t EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        CLK,
  input  logic        nRST,
  input  word_t       pc_out,
  input  logic        ihit,
  input  logic        dstall,
  input  logic        halt,
  input  logic [1:0]  pc_src,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] jaddr,
  input  word_t       rs_data,
  output word_t       pc_in,
  output logic        pcWEN,
  output word_t       pc_plus4,
  output logic        halted,
`ifdef PC_ALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic        redir_pend
);

  pcseq_state_t state, state_nx;
  word_t        buf_q, buf_nx;
  word_t        target, sel_tgt, sel_pc;
  logic         is_xfer;
  logic         accept;
  logic         run_write;
  logic         sel_mis;

  next_pc_calc u_calc (
    .pc_out   (pc_out),
    .pc_src   (pc_src_t'(pc_src)),
    .br_taken (br_taken),
    .imm16    (imm16),
    .jaddr    (jaddr),
    .rs_data  (rs_data),
    .pc_plus4 (pc_plus4),
    .target   (target),
    .is_xfer  (is_xfer)
  );

  assign accept    = ihit & ~dstall;
  assign run_write = accept & ~halt;
  assign sel_tgt   = (state == REDIR) ? buf_q : target;

`ifdef PC_ALIGN_TRAP_EN
  assign sel_mis  = |sel_tgt[1:0];
  assign sel_pc   = sel_mis ? EXC_VECTOR : sel_tgt;
  assign misalign = (state == TRAP);
`else
  logic unused_exc_vector;
  assign sel_mis           = 1'b0;
  assign sel_pc            = sel_tgt;
  assign unused_exc_vector = ^{EXC_VECTOR, sel_mis};
`endif

  // State register and redirect buffer
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      buf_q <= '0;
    end else begin
      state <= state_nx;
      buf_q <= buf_nx;
    end
  end

  // Next state: halt wins over any transfer; a stalled transfer is buffered
  always_comb begin
    state_nx = state;
    buf_nx   = buf_q;
    case (state)
      RUN: begin
        if (halt) begin
          if (accept) state_nx = HALT;
        end else if (is_xfer && dstall) begin
          state_nx = REDIR;
          buf_nx   = target;
        end else if (run_write && sel_mis) begin
          state_nx = TRAP;
        end
      end
      REDIR: begin
        if (accept) begin
          state_nx = sel_mis ? TRAP : RUN;
          buf_nx   = '0;
        end
      end
      HALT:    state_nx = HALT;
      TRAP:    state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  // Outputs: reset forces PC_INIT and no write; otherwise state-qualified
  always_comb begin
    pc_in      = sel_pc;
    pcWEN      = 1'b0;
    halted     = (state == HALT);
    redir_pend = (state == REDIR);
    case (state)
      RUN:     pcWEN = run_write;
      REDIR:   pcWEN = accept;
      default: pcWEN = 1'b0;
    endcase
    if (!nRST) begin
      pc_in = PC_INIT;
      pcWEN = 1'b0;
    end
  end

endmodule
